memory_stage: RTL

Memory (M) stage of the five-stage MIPS pipeline, directly downstream of the Execute stage. It takes the ALU result (effective address), the forwarded rt value and the pending write-back data latched into the E/M register, and performs data-memory loads and stores (word, half, byte). It then hands the final register write-back value to the M/W register. It owns the data memory array and reports which operands it reads in M, for the hazard unit.

---
 rtl/memory_stage_pkg.sv | 53 +++++
 rtl/memory_stage_dm_ram.sv | 46 ++++
 rtl/memory_stage.sv | 79 +++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the M stage: memory opcodes, load/store encodings
// and the M-stage slice of the control decoder.
package memory_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_WORD,
        LD_HALF_S,
        LD_HALF_U,
        LD_BYTE_S,
        LD_BYTE_U
    } ld_kind_e;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_WORD,
        ST_HALF,
        ST_BYTE
    } st_width_e;

    typedef struct packed {
        st_width_e st;
        ld_kind_e  ld;
        logic      m2use;
    } mem_ctrl_t;

    function automatic mem_ctrl_t decode_mem(input logic [5:0] op);
        mem_ctrl_t c;
        c = '{st: ST_NONE, ld: LD_NONE, m2use: 1'b0};
        case (op)
            OP_LW:   c.ld = LD_WORD;
            OP_LH:   c.ld = LD_HALF_S;
            OP_LHU:  c.ld = LD_HALF_U;
            OP_LB:   c.ld = LD_BYTE_S;
            OP_LBU:  c.ld = LD_BYTE_U;
            OP_SW:   c = '{st: ST_WORD, ld: LD_NONE, m2use: 1'b1};
            OP_SH:   c = '{st: ST_HALF, ld: LD_NONE, m2use: 1'b1};
            OP_SB:   c = '{st: ST_BYTE, ld: LD_NONE, m2use: 1'b1};
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/memory_stage_dm_ram.sv
// Data memory: asynchronous read, byte-enabled synchronous write,
// synchronous clear on reset, and a simulation write log.
module dm_ram
    import memory_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DM_AW-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic [31:0]      log_pc,
    input  logic [31:0]      log_addr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DM_WORDS];
    logic [31:0] merged;

    assign rdata = mem[addr];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // NOTE: the array is cleared on reset because loads right after reset must
    // read 0; this rules out a plain block-RAM mapping, which is accepted here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (|be) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            mem[addr] <= merged;
`ifndef SYNTHESIS
            $display("@%08h: *%08h <= %08h", log_pc, log_addr, merged);
`endif
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS M stage: store lane steering, load lane select/extension and the
// write-back mux in front of the M/W register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrM,
    input  logic [31:0] PCM,
    input  logic [31:0] ResM,
    input  logic [31:0] WDM,
    input  logic [31:0] FwdM2,
    output logic [31:0] WDMW,
    output logic        M2Use
);

    mem_ctrl_t   ctrl;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic        unused_instr_bits;

    assign ctrl              = decode_mem(InstrM[31:26]);
    assign M2Use             = ctrl.m2use;
    assign unused_instr_bits = ^InstrM[25:0];

    // Narrow store data is replicated across all lanes; the byte enable picks the live one.
    always_comb begin
        be    = 4'b0000;
        wdata = FwdM2;
        case (ctrl.st)
            ST_WORD: be = 4'b1111;
            ST_HALF: begin
                be    = ResM[1] ? 4'b1100 : 4'b0011;
                wdata = {2{FwdM2[15:0]}};
            end
            ST_BYTE: begin
                be    = 4'b0001 << ResM[1:0];
                wdata = {4{FwdM2[7:0]}};
            end
            default: ;
        endcase
    end

    dm_ram #(
        .DM_WORDS(DM_WORDS),
        .DM_AW   (DM_AW)
    ) u_dm_ram (
        .clk     (clk),
        .reset   (reset),
        .addr    (ResM[DM_AW+1:2]),
        .be      (be),
        .wdata   (wdata),
        .log_pc  (PCM),
        .log_addr({ResM[31:2], 2'b00}),
        .rdata   (rdata)
    );

    assign half     = ResM[1] ? rdata[31:16] : rdata[15:0];
    assign byte_sel = ResM[0] ? half[15:8]   : half[7:0];

    always_comb begin
        WDMW = WDM;
        case (ctrl.ld)
            LD_WORD:   WDMW = rdata;
            LD_HALF_S: WDMW = {{16{half[15]}}, half};
            LD_HALF_U: WDMW = {16'h0000, half};
            LD_BYTE_S: WDMW = {{24{byte_sel[7]}}, byte_sel};
            LD_BYTE_U: WDMW = {24'h000000, byte_sel};
            default:   ;
        endcase
    end

endmodule
